// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, FSM state encoding and decode helpers for the 4x4 keypad scanner.
// Pure definitions: no latency, no flow control.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Key codes are {row[1:0], col[1:0]}.
    localparam logic [3:0] KEY_A    = 4'h3;
    localparam logic [3:0] KEY_B    = 4'h7;
    localparam logic [3:0] KEY_C    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Only the digits 1-9 carry a value; '0' is deliberately reported as 0.
    function automatic logic [3:0] code_to_digit(input logic [3:0] code);
        logic [3:0] digit;
        case (code)
            4'h0:    digit = 4'd1;
            4'h1:    digit = 4'd2;
            4'h2:    digit = 4'd3;
            4'h4:    digit = 4'd4;
            4'h5:    digit = 4'd5;
            4'h6:    digit = 4'd6;
            4'h8:    digit = 4'd7;
            4'h9:    digit = 4'd8;
            4'hA:    digit = 4'd9;
            KEY_A, KEY_B, KEY_C, KEY_D,
            KEY_0, KEY_STAR, KEY_HASH:
                     digit = 4'd0;
            default: digit = 4'd0;
        endcase
        return digit;
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] row;
        if (!rows_n[0])
            row = 2'd0;
        else if (!rows_n[1])
            row = 2'd1;
        else if (!rows_n[2])
            row = 2'd2;
        else
            row = 2'd3;
        return row;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-clk tick every SCAN_DIV cycles, first tick SCAN_DIV-1 clk after reset.
// No backpressure; tick is combinational from the counter register.
module tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scan, debounce and decode; emits one-clk registered key events.
// Press latency: first seeing tick + (DEBOUNCE_SCANS-1) ticks + 1 clk; no backpressure, no auto-repeat.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       start,
    output logic       clear,
    output logic [3:0] key_code
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic             tick;
    state_t           state;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;
    logic             key_seen;
    logic [3:0]       hit_code;

    // Rows idle high, so the synchroniser resets to "no key".
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
        end
    end

    tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign key_seen = ~&row_s;
    assign hit_code = {lowest_low_row(row_s), col_idx};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_n     <= COL_RESET;
            cnt       <= '0;
            cand      <= 4'h0;
            key_value <= 4'd0;
            key_valid <= 1'b0;
            start     <= 1'b0;
            clear     <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            key_value <= 4'd0;
            key_valid <= 1'b0;
            start     <= 1'b0;
            clear     <= 1'b0;

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (key_seen) begin
                            cand  <= hit_code;
                            cnt   <= CNT_ONE;
                            state <= (CNT_ONE == CNT_MAX) ? EMIT : DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_n   <= col_drive(col_idx + 2'd1);
                        end
                    end
                end

                // Column stays frozen; any change sends us back to rescan this column.
                DEBOUNCE: begin
                    if (tick) begin
                        if (key_seen && (hit_code == cand)) begin
                            cnt <= cnt + CNT_ONE;
                            if (cnt == CNT_LAST) begin
                                state <= EMIT;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    end
                end

                EMIT: begin
                    key_valid <= 1'b1;
                    key_code  <= cand;
                    key_value <= code_to_digit(cand);
                    start     <= (cand == KEY_HASH);
                    clear     <= (cand == KEY_STAR);
                    cnt       <= '0;
                    state     <= HOLD;
                end

                // Wait for DEBOUNCE_SCANS quiet ticks on the frozen column before rescanning.
                HOLD: begin
                    if (tick) begin
                        if (key_seen) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= SCAN;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and decodes the pressed key.
- Emits single-cycle event pulses to the amount manager stage: digits on key_value, '#' as start, '*' as clear.
- Sits directly upstream of the amount manager. Runs on the 50 MHz system clock.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan tick (1 kHz at 50 MHz); must be >= 2.
- DEBOUNCE_SCANS, 20, consecutive identical ticks required for both press and release acceptance; must be >= 1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous, active-high reset (asserted = 1)
- row_n  input  4  keypad rows, active-low, asynchronous, pulled up externally
- col_n  output  4  column drive, one-hot-low
- key_value  output  4  digit 1-9 during the emit cycle; 0 at all other times, including for key '0'
- key_valid  output  1  one-cycle pulse for any accepted key
- start  output  1  one-cycle pulse when '#' is accepted
- clear  output  1  one-cycle pulse when '*' is accepted
- key_code  output  4  raw index {row,col} of the last accepted key; held until the next accept

Behaviour:
- Reset (rst_n=1 at a clk edge): state=SCAN, column index=0, col_n=4'b1110, tick and debounce counters=0, and all outputs 0 except col_n.
- Synchronisation: row_n passes through 2 flops (row_s) before any use. No combinational path from row_n to any output.
- Tick: a free-running counter runs 0..SCAN_DIV-1; tick=1 for one clk when it wraps. The counter is cleared by reset.
- Key layout, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - key_code = {r[1:0], c[1:0]}.
- Multiple rows low in the same column: the lowest row index wins.
- FSM states:
  - SCAN: on tick, if any row_s bit is low, latch {row,col} as cand, set cnt=1, go DEBOUNCE. If cnt already equals DEBOUNCE_SCANS, go EMIT instead. Otherwise advance the column, wrapping 3->0, and update col_n.
  - DEBOUNCE: column frozen. On tick:
    - same code still present: cnt++; when cnt reaches DEBOUNCE_SCANS, go EMIT.
    - different code, or no key: cnt=0, go SCAN, column unchanged (rescanned next tick).
  - EMIT: exactly one clk.
    - key_valid=1; key_code<=cand.
    - key_value=digit for 1-9, else 0.
    - start=1 if '#'; clear=1 if '*'.
    - A, B, C, D and '0' raise key_valid only.
    - Next state HOLD with cnt=0.
  - HOLD: column frozen. On tick, if the column's rows are all high: cnt++, and on reaching DEBOUNCE_SCANS go SCAN with cnt=0. Any low row: cnt=0. No second event is emitted while held (no auto-repeat).
- Output timing: key_value, key_valid, start and clear are registered and asserted only in the EMIT cycle. start and clear are never high together.
- Press latency: first tick seeing the key, plus (DEBOUNCE_SCANS-1) further ticks, plus 1 clk to EMIT.
- A bounce during DEBOUNCE restarts acceptance. A bounce during HOLD restarts the release count.
- A second key pressed in another column during HOLD is ignored until release completes.
- Reset mid-operation: returns to the reset values on the next clk, with no pulse emitted. A pending EMIT is dropped.
- Width rules:
  - cnt is wide enough for DEBOUNCE_SCANS, i.e. $clog2(DEBOUNCE_SCANS+1).
  - The tick counter is $clog2(SCAN_DIV) bits.

Decomposition:
- Shared package holds:
  - key codes KEY_STAR=4'hC, KEY_0=4'hD, KEY_HASH=4'hE, KEY_A..KEY_D;
  - FSM state encoding (SCAN, DEBOUNCE, EMIT, HOLD);
  - the 16-entry code->digit map function.
- One natural sub-module, tick_gen (parameter SCAN_DIV; outputs tick), reusable for the 1 Hz timing divider elsewhere.
- Synchroniser and FSM stay inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Reset, no key held for 100 clk -> col_n cycles 1110,1101,1011,0111,1110 every 4 clk; all pulses 0; key_value=0.
- Press '5' (row1 low while col1 driven) and hold -> exactly one clk with key_valid=1, key_value=4'd5, key_code=4'h5. No further pulse until release plus 3 quiet ticks.
- Press '#' -> start=1 for one clk; key_value=0; key_code=4'hE. Press '*' -> clear=1 for one clk, start stays 0.
- Press '7' with a bounce (row high for one tick after 2 good ticks) -> no emit at the original deadline; emit occurs 3 clean ticks after the bounce ends.
- Rows 0 and 2 low together in col2 -> key_code=4'h2, key_value=3. Then key '0' -> key_valid=1, key_value=0, key_code=4'hD.
- Assert rst_n during DEBOUNCE -> next clk col_n=1110, no pulse. After release of rst_n, a fresh press is accepted normally.
